fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side master for the synchronous FIFO. It drains words over the FIFO read port (r_en/data_out/empty)
//  and presents them downstream as a valid/ready stream. It absorbs the FIFO's one-cycle registered read
//  latency with a small credit-controlled skid buffer, so throughput is one word per clock under back-pressure.
// PARAMETERS
//  width       8   data width; matches the FIFO width
//  skid_depth  4   skid-buffer entries; power of two, >=3 (3 is the minimum for full throughput)
//  cnt_width   16  width of the delivered-word counter
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous reset, active-high
//  fifo_empty  in   1           FIFO empty flag
//  fifo_data   in   width       FIFO data_out; valid the cycle after r_en was sampled with !empty
//  fifo_r_en   out  1           FIFO read enable
//  enable      in   1           1 = issue new reads; 0 = stop fetching, still deliver held data
//  flush       in   1           discard buffered and in-flight words
//  m_valid     out  1           downstream word valid
//  m_data      out  width       downstream word
//  m_ready     in   1           downstream accept
//  rd_count    out  cnt_width   words delivered since reset; wraps
//  idle        out  1           no buffered and no in-flight words
// BEHAVIOUR
//  - Reset: the design is clocked by clk; rst is synchronous and active-high and dominates flush.
//    Outputs after reset: fifo_r_en=0, m_valid=0, m_data=0, rd_count=0, idle=1.
//    Internal state after reset: occ=0, inflight=0, wptr=rptr=0.
//  - State: occ (0..skid_depth), inflight (1 bit), wptr/rptr (log2(skid_depth) bits, wrap modulo skid_depth).
//  - Read issue: fifo_r_en = !rst & enable & !flush & !fifo_empty & ((occ+inflight) < skid_depth).
//    Combinational from registers and these inputs only. No path from m_ready.
//    Reads only when !fifo_empty, so it never reads an empty FIFO.
//  - Capture: inflight <= fifo_r_en each edge. When inflight=1, fifo_data is written to buf[wptr] at that edge,
//    then wptr++ and occ++.
//  - Output: m_valid = (occ!=0) & !flush; m_data = buf[rptr], or 0 when occ=0.
//    Pop on m_valid & m_ready: rptr++, occ--, rd_count++ (modulo 2^cnt_width).
//  - Push and pop on the same edge: occ unchanged, both pointers advance.
//  - Latency: fifo_r_en high in cycle N, word captured at the end of N+1, m_valid high in N+2.
//    With m_ready held at 1, one word per cycle in steady state.
//  - Stall: while m_valid & !m_ready, m_data and m_valid hold stable.
//  - Credit rule guarantees no overflow. Assert occ+inflight <= skid_depth every cycle.
//  - enable=0 mid-stream: the in-flight word is still captured, buffered words drain normally, no new fifo_r_en.
//  - flush=1 at an edge: occ<=0, wptr<=rptr<=0, and a word arriving that edge (inflight=1) is dropped.
//    No pop and no rd_count change while flush=1. inflight<=0 because fifo_r_en=0.
//  - FIFO goes empty while draining: fifo_r_en drops in that cycle; buffered words continue to drain.
//  - rst mid-operation: all buffered and in-flight data is lost.
//    A read the FIFO accepted in the reset cycle is not captured.
//  - idle = (occ==0) & (inflight==0).
// STRUCTURE
//  - fifo_pkg: default width/depth constants, cnt_width default, and a clog2 function for pointer widths.
//    Shared with the FIFO block.
//  - Sub-module fifo_skid_buf: skid_depth x width ring (buf, wptr, rptr, occ) with push/pop/clear inputs.
//  - The top level holds the credit/issue logic, inflight, rd_count and idle.
// TESTING (bench instantiates the FIFO width=8 depth=8 feeding this block)
//  1. Reset hold: rst=1 with FIFO non-empty -> fifo_r_en=0, m_valid=0, rd_count=0, idle=1.
//  2. Streaming: write 1..8, m_ready=1 -> m_data 1..8 on 8 consecutive cycles.
//     First m_valid 2 cycles after the first fifo_r_en; rd_count=8; idle=1 afterwards.
//  3. Back-pressure: write 1..8, m_ready=0 -> fifo_r_en stops after 4 reads, m_data=1 held, FIFO keeps 4 words.
//     Then m_ready=1 -> 1..8 in order with no gaps after restart.
//  4. Random stall: m_ready random 50%, 200 words -> in-order, no loss or duplication; rd_count=200.
//  5. Flush: 3 words buffered plus 1 in flight, pulse flush one cycle -> those 4 words are never seen, occ=0.
//     The next word from the FIFO is delivered correctly.
//  6. enable=0 with FIFO holding 5 words -> no fifo_r_en, held words drain, idle=1.
//     enable=1 -> remaining words delivered.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO and its stream reader.
// Pointer widths are derived with clog2 so both blocks size their indices the same way.
package fifo_pkg;

   localparam int default_width      = 8;
   localparam int default_depth      = 8;
   localparam int default_skid_depth = 4;
   localparam int default_cnt_width  = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small ring buffer that catches words arriving one cycle after they were requested.
// Clear empties the ring and wins over a simultaneous push or pop.
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int width = default_width,
   parameter int depth = default_skid_depth,
   localparam int ptr_w = clog2(depth),
   localparam int occ_w = ptr_w + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] rd_data,
   output logic [occ_w-1:0] occ
);

   logic [width-1:0] mem_r [depth];
   logic [ptr_w-1:0] wptr_r;
   logic [ptr_w-1:0] rptr_r;
   logic [occ_w-1:0] occ_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since depth is a power of two
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr_r <= {ptr_w{1'b0}};
         rptr_r <= {ptr_w{1'b0}};
         occ_r  <= {occ_w{1'b0}};
      end else begin
         if (push) begin
            wptr_r <= wptr_r + ptr_w'(1'b1);
         end
         if (pop) begin
            rptr_r <= rptr_r + ptr_w'(1'b1);
         end
         case ({push, pop})
            2'b10:   occ_r <= occ_r + occ_w'(1'b1);
            2'b01:   occ_r <= occ_r - occ_w'(1'b1);
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Storage write; contents need no reset because the read side masks an empty ring
   always_ff @(posedge clk) begin
      if (push && !rst && !clear) begin
         mem_r[wptr_r] <= push_data;
      end
   end

   assign rd_data = (occ_r != {occ_w{1'b0}}) ? mem_r[rptr_r] : {width{1'b0}};
   assign occ     = occ_r;

endmodule

// File: rtl/fifo_stream_reader_chk.sv
// Run-time invariants for the stream reader: credit bound, no read of an empty FIFO,
// and a stalled downstream word that stays put until accepted.
module fifo_stream_reader_chk #(
   parameter int width      = 8,
   parameter int occ_w      = 3,
   parameter int skid_depth = 4
) (
   input logic             clk,
   input logic             rst,
   input logic [occ_w-1:0] occ,
   input logic             inflight,
   input logic             fifo_r_en,
   input logic             fifo_empty,
   input logic             flush,
   input logic             m_valid,
   input logic             m_ready,
   input logic [width-1:0] m_data
);

   logic             stall_r;
   logic [width-1:0] stall_data_r;

   // Remember whether the previous cycle ended in a downstream stall
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r      <= 1'b0;
         stall_data_r <= {width{1'b0}};
      end else begin
         stall_r      <= m_valid && !m_ready;
         stall_data_r <= m_data;
      end
   end

   // Invariants sampled each rising edge outside reset
   always @(posedge clk) begin
      if (!rst) begin
         assert (({1'b0, occ} + {{occ_w{1'b0}}, inflight}) <= (occ_w + 1)'(skid_depth));
         assert (!(fifo_r_en && fifo_empty));
         if (stall_r && !flush) begin
            assert (m_valid && (m_data == stall_data_r));
         end
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads against skid-buffer credit and
// presents the captured words downstream as a valid/ready stream, one word per clock.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int width      = default_width,
   parameter int skid_depth = default_skid_depth,
   parameter int cnt_width  = default_cnt_width
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [width-1:0]     fifo_data,
   output logic                 fifo_r_en,
   input  logic                 enable,
   input  logic                 flush,
   output logic                 m_valid,
   output logic [width-1:0]     m_data,
   input  logic                 m_ready,
   output logic [cnt_width-1:0] rd_count,
   output logic                 idle
);

   localparam int occ_w = clog2(skid_depth) + 1;
   localparam logic [occ_w:0] credit_limit = (occ_w + 1)'(skid_depth);

   logic                 inflight_r;
   logic [cnt_width-1:0] rd_count_r;
   logic [occ_w-1:0]     occ_s;
   logic [occ_w:0]       pending_s;
   logic                 credit_s;
   logic                 r_en_s;
   logic                 m_valid_s;
   logic                 push_s;
   logic                 pop_s;
   logic [width-1:0]     buf_data_s;

   // Issue and handshake decode; every word already requested holds a slot, so m_ready never gates reads
   always_comb begin
      pending_s = {1'b0, occ_s} + {{occ_w{1'b0}}, inflight_r};
      credit_s  = (pending_s < credit_limit);
      r_en_s    = !rst && enable && !flush && !fifo_empty && credit_s;
      m_valid_s = (occ_s != {occ_w{1'b0}}) && !flush;
      push_s    = inflight_r && !flush;
      pop_s     = m_valid_s && m_ready;
   end

   // Track the outstanding FIFO read and count delivered words
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_r <= 1'b0;
         rd_count_r <= {cnt_width{1'b0}};
      end else begin
         inflight_r <= r_en_s;
         if (pop_s) begin
            rd_count_r <= rd_count_r + cnt_width'(1'b1);
         end
      end
   end

   fifo_skid_buf #(
      .width (width),
      .depth (skid_depth)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push_s),
      .push_data (fifo_data),
      .pop       (pop_s),
      .rd_data   (buf_data_s),
      .occ       (occ_s)
   );

   fifo_stream_reader_chk #(
      .width      (width),
      .occ_w      (occ_w),
      .skid_depth (skid_depth)
   ) u_chk (
      .clk        (clk),
      .rst        (rst),
      .occ        (occ_s),
      .inflight   (inflight_r),
      .fifo_r_en  (r_en_s),
      .fifo_empty (fifo_empty),
      .flush      (flush),
      .m_valid    (m_valid_s),
      .m_ready    (m_ready),
      .m_data     (buf_data_s)
   );

   assign fifo_r_en = r_en_s;
   assign m_valid   = m_valid_s;
   assign m_data    = buf_data_s;
   assign rd_count  = rd_count_r;
   assign idle      = (occ_s == {occ_w{1'b0}}) && !inflight_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: a behavioural 8x8 FIFO feeds the reader; a queue of written words is the
// expected downstream order, and each scenario task checks its own observations.
module tb_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst, fifo_rst, enable, flush, m_ready;
   logic        fifo_empty, fifo_r_en, m_valid, idle;
   logic [7:0]  fifo_data, m_data;
   logic [15:0] rd_count;
   logic        fifo_wr;
   logic [7:0]  fifo_wdata;

   logic [7:0]  f_mem [8];
   int          f_wp = 0, f_rp = 0, f_cnt = 0, f_reads = 0, cyc = 0;
   logic        f_rd, f_wr;

   logic [7:0]  exp_q [$];
   logic [15:0] exp_count = 16'd0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.width(8), .skid_depth(4), .cnt_width(16)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_r_en(fifo_r_en), .enable(enable), .flush(flush), .m_valid(m_valid),
      .m_data(m_data), .m_ready(m_ready), .rd_count(rd_count), .idle(idle)
   );

   // Behavioural FIFO with a registered read port
   assign fifo_empty = (f_cnt == 0);
   assign f_rd = fifo_r_en && (f_cnt != 0);
   assign f_wr = fifo_wr && (f_cnt < 8);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rst) begin
         f_wp <= 0; f_rp <= 0; f_cnt <= 0; fifo_data <= 8'h00;
      end else begin
         if (f_rd) begin
            fifo_data <= f_mem[f_rp];
            f_rp <= (f_rp + 1) % 8;
            f_reads <= f_reads + 1;
         end
         if (f_wr) begin
            f_mem[f_wp] <= fifo_wdata;
            f_wp <= (f_wp + 1) % 8;
         end
         f_cnt <= f_cnt + (f_wr ? 1 : 0) - (f_rd ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      fifo_wr = 1'b0;
   endtask

   task automatic write_word(input logic [7:0] d);
      fifo_wr = 1'b1;
      fifo_wdata = d;
      exp_q.push_back(d);
   endtask

   task automatic test_reset();
      rst = 1'b1; fifo_rst = 1'b1; enable = 1'b1; flush = 1'b0; m_ready = 1'b0;
      fifo_wr = 1'b0; fifo_wdata = 8'h00;
      tick(); tick();
      fifo_rst = 1'b0;
      tick(); write_word(8'hA1);
      tick(); write_word(8'hA2);
      tick(); tick();
      @(negedge clk);
      checks += 6;
      if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
      if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
      if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
      if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
      if (f_cnt != 2) begin errors++; $display("FAIL reset_fifo_untouched: got %0d want 2", f_cnt); end
      tick(); fifo_rst = 1'b1;
      tick(); fifo_rst = 1'b0; exp_q.delete();
      tick(); rst = 1'b0; enable = 1'b0;
   endtask

   task automatic test_streaming();
      int first_ren = -1, first_valid = -1, first_acc = -1, last_acc = -1, n_acc = 0;
      logic [8:0] exp9;
      m_ready = 1'b1; enable = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick(); write_word(8'(i));
      end
      tick(); tick();
      enable = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (fifo_r_en && first_ren < 0) first_ren = cyc;
         if (m_valid && first_valid < 0) first_valid = cyc;
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL stream_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc; n_acc++;
         end
         tick();
      end
      @(negedge clk);
      checks += 5;
      if (first_valid - first_ren != 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", first_valid - first_ren); end
      if (n_acc != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", n_acc); end
      if (last_acc - first_acc != 7) begin errors++; $display("FAIL stream_gapless: span %0d want 7", last_acc - first_acc); end
      if (rd_count !== 16'd8) begin errors++; $display("FAIL stream_rd_count: got %0d want 8", rd_count); end
      if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle: got %b want 1", idle); end
   endtask

   task automatic test_backpressure();
      int reads0, first_acc = -1, last_acc = -1, n_acc = 0;
      logic [8:0] exp9;
      m_ready = 1'b0; enable = 1'b1; reads0 = f_reads;
      for (int i = 1; i <= 8; i++) begin
         tick(); write_word(8'(i));
      end
      for (int c = 0; c < 6; c++) tick();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== 8'd1) begin errors++; $display("FAIL bp_hold: valid=%b data=%h want 1/01", m_valid, m_data); end
         tick();
      end
      @(negedge clk);
      checks += 3;
      if (f_reads - reads0 != 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", f_reads - reads0); end
      if (f_cnt != 4) begin errors++; $display("FAIL bp_fifo_left: got %0d want 4", f_cnt); end
      if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL bp_r_en: got %b want 0", fifo_r_en); end
      tick(); m_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL bp_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc; n_acc++;
         end
         tick();
      end
      checks += 2;
      if (n_acc != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", n_acc); end
      if (last_acc - first_acc != 7) begin errors++; $display("FAIL bp_gapless: span %0d want 7", last_acc - first_acc); end
   endtask

   task automatic test_random();
      int written = 0, n_acc = 0;
      logic prev_stall = 1'b0;
      logic [7:0] prev_data = 8'h00;
      logic [8:0] exp9;
      enable = 1'b1;
      for (int c = 0; c < 6000 && n_acc < 200; c++) begin
         tick();
         m_ready = 1'($urandom_range(0, 1));
         if (written < 200 && f_cnt < 8 && $urandom_range(0, 3) != 0) begin
            write_word(8'($urandom_range(0, 255)));
            written++;
         end
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin errors++; $display("FAIL rand_stall: valid=%b data=%h want 1/%h", m_valid, m_data, prev_data); end
         end
         prev_stall = m_valid && !m_ready;
         prev_data = m_data;
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL rand_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            n_acc++;
         end
      end
      tick(); m_ready = 1'b0;
      @(negedge clk);
      checks += 3;
      if (n_acc != 200) begin errors++; $display("FAIL rand_count: got %0d want 200", n_acc); end
      if (rd_count !== exp_count) begin errors++; $display("FAIL rand_rd_count: got %0d want %0d", rd_count, exp_count); end
      if (exp_count !== 16'd216) begin errors++; $display("FAIL rand_total: got %0d want 216", exp_count); end
   endtask

   task automatic test_flush();
      int reads0, nr = 0, n_acc = 0;
      logic [8:0] exp9;
      m_ready = 1'b0; enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); write_word(8'h50 + 8'(i));
      end
      tick(); tick();
      enable = 1'b1; reads0 = f_reads;
      for (int c = 0; c < 20 && nr < 4; c++) begin
         @(negedge clk);
         if (fifo_r_en) nr++;
         tick();
      end
      flush = 1'b1;
      @(negedge clk);
      checks += 2;
      if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL flush_r_en: got %b want 0", fifo_r_en); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
      tick(); flush = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      checks += 2;
      if (f_reads - reads0 != 4) begin errors++; $display("FAIL flush_dropped: got %0d want 4", f_reads - reads0); end
      if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b want 1", idle); end
      for (int i = 0; i < 4; i++) if (exp_q.size() != 0) void'(exp_q.pop_front());
      for (int c = 0; c < 12; c++) begin
         tick();
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL flush_next_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            n_acc++;
         end
      end
      checks += 2;
      if (n_acc != 1) begin errors++; $display("FAIL flush_after_count: got %0d want 1", n_acc); end
      if (rd_count !== exp_count) begin errors++; $display("FAIL flush_rd_count: got %0d want %0d", rd_count, exp_count); end
   endtask

   task automatic test_enable();
      int n_acc = 0, ren_seen = 0;
      logic [8:0] exp9;
      enable = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); write_word(8'hC0 + 8'(i));
      end
      for (int c = 0; c < 6; c++) tick();
      enable = 1'b0; m_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 5) write_word(8'hD0 + 8'(c));
         @(negedge clk);
         if (fifo_r_en) ren_seen++;
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL en_drain_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            n_acc++;
         end
         tick();
      end
      @(negedge clk);
      checks += 4;
      if (ren_seen != 0) begin errors++; $display("FAIL en_no_read: got %0d reads want 0", ren_seen); end
      if (n_acc != 3) begin errors++; $display("FAIL en_drain_count: got %0d want 3", n_acc); end
      if (idle !== 1'b1) begin errors++; $display("FAIL en_idle: got %b want 1", idle); end
      if (f_cnt != 5) begin errors++; $display("FAIL en_fifo_held: got %0d want 5", f_cnt); end
      tick(); enable = 1'b1; n_acc = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (exp_q.size() != 0) exp9 = {1'b0, exp_q.pop_front()}; else exp9 = 9'h100;
            checks++;
            if ({1'b0, m_data} !== exp9) begin errors++; $display("FAIL en_resume_word: got %h want %h", m_data, exp9); end
            exp_count = exp_count + 16'd1;
            n_acc++;
         end
         tick();
      end
      @(negedge clk);
      checks += 3;
      if (n_acc != 5) begin errors++; $display("FAIL en_resume_count: got %0d want 5", n_acc); end
      if (idle !== 1'b1) begin errors++; $display("FAIL en_final_idle: got %b want 1", idle); end
      if (rd_count !== exp_count) begin errors++; $display("FAIL en_rd_count: got %0d want %0d", rd_count, exp_count); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_random();
      test_flush();
      test_enable();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
